// File: rtl/mips16_run_ctrl_if.sv
// rtl/mips16_run_ctrl_if.sv - command port bundle between debug host and run controller
interface mips16_run_ctrl_if #(
  parameter int PC_W = 16
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [2:0]      cmd_op;
  logic            cmd_idx;
  logic [PC_W-1:0] cmd_data;

  // host side drives commands, controller answers with ready
  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_idx,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_idx,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/mips16_run_ctrl.sv
// rtl/mips16_run_ctrl.sv - run/halt/step/breakpoint sequencer for the 16-bit MIPS core
module mips16_run_ctrl #(
  parameter int PC_W     = 16,
  parameter int CNT_W    = 16,
  parameter int HOLD_CYC = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  mips16_run_ctrl_if.slave io_cmd,
  input  logic [PC_W-1:0]  i_pc,
  output logic             o_cpu_en,
  output logic             o_cpu_reset,
  output logic             o_halted,
  output logic             o_bp_hit,
  output logic             o_bp_hit_idx,
  output logic [CNT_W-1:0] o_retired
);

  localparam int HC_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HC_W-1:0] HOLD_RELOAD = HC_W'(HOLD_CYC - 1);

  localparam logic [1:0] S_HOLD = 2'd0;
  localparam logic [1:0] S_HALT = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_STEP = 2'd3;

  localparam logic [2:0] OP_HALT      = 3'd0;
  localparam logic [2:0] OP_RUN       = 3'd1;
  localparam logic [2:0] OP_STEP      = 3'd2;
  localparam logic [2:0] OP_SET_BP    = 3'd3;
  localparam logic [2:0] OP_CLR_BP    = 3'd4;
  localparam logic [2:0] OP_CPU_RESET = 3'd5;

  logic [1:0]       r_state;
  logic [HC_W-1:0]  r_hold_cnt;
  logic [PC_W-1:0]  r_bp0_addr;
  logic [PC_W-1:0]  r_bp1_addr;
  logic             r_bp0_en;
  logic             r_bp1_en;
  logic             r_skip;
  logic [CNT_W-1:0] r_step_cnt;
  logic [CNT_W-1:0] r_retired;
  logic             r_bp_hit;
  logic             r_bp_hit_idx;

  logic             w_ready;
  logic             w_fire;
  logic             w_halt_cmd;
  logic             w_rst_cmd;
  logic             w_m0;
  logic             w_m1;
  logic             w_stop;
  logic             w_active;
  logic             w_cpu_en;
  logic [CNT_W-1:0] w_step_load;

  // command handshake, breakpoint compare and the commit qualifier
  always_comb begin
    w_ready     = (r_state != S_HOLD);
    w_fire      = io_cmd.cmd_valid & w_ready;
    w_halt_cmd  = w_fire & (io_cmd.cmd_op == OP_HALT);
    w_rst_cmd   = w_fire & (io_cmd.cmd_op == OP_CPU_RESET);
    w_m0        = r_bp0_en & (i_pc == r_bp0_addr);
    w_m1        = r_bp1_en & (i_pc == r_bp1_addr);
    // skip lets the core leave a breakpoint PC it is currently parked on
    w_stop      = (w_m0 | w_m1) & ~r_skip;
    w_active    = (r_state == S_RUN) | (r_state == S_STEP);
    w_cpu_en    = w_active & ~w_stop & ~w_halt_cmd & ~w_rst_cmd;
    w_step_load = (io_cmd.cmd_data == '0) ? CNT_W'(1) : CNT_W'(io_cmd.cmd_data);
  end

  assign io_cmd.cmd_ready = w_ready;
  assign o_cpu_en         = w_cpu_en;
  assign o_cpu_reset      = (r_state == S_HOLD);
  assign o_halted         = (r_state == S_HALT);
  assign o_bp_hit         = r_bp_hit;
  assign o_bp_hit_idx     = r_bp_hit_idx;
  assign o_retired        = r_retired;

  // sequencer state, breakpoints and counters; CPU_RESET outranks stop/halt/step end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_HOLD;
      r_hold_cnt   <= HOLD_RELOAD;
      r_bp0_addr   <= '0;
      r_bp1_addr   <= '0;
      r_bp0_en     <= 1'b0;
      r_bp1_en     <= 1'b0;
      r_skip       <= 1'b0;
      r_step_cnt   <= '0;
      r_retired    <= '0;
      r_bp_hit     <= 1'b0;
      r_bp_hit_idx <= 1'b0;
    end else if (w_rst_cmd) begin
      r_state    <= S_HOLD;
      r_hold_cnt <= HOLD_RELOAD;
      r_retired  <= '0;
      r_skip     <= 1'b0;
      r_bp_hit   <= 1'b0;
    end else begin
      if (w_fire && io_cmd.cmd_op == OP_SET_BP) begin
        if (io_cmd.cmd_idx) begin
          r_bp1_addr <= io_cmd.cmd_data;
          r_bp1_en   <= 1'b1;
        end else begin
          r_bp0_addr <= io_cmd.cmd_data;
          r_bp0_en   <= 1'b1;
        end
      end
      if (w_fire && io_cmd.cmd_op == OP_CLR_BP) begin
        if (io_cmd.cmd_idx) r_bp1_en <= 1'b0;
        else                r_bp0_en <= 1'b0;
      end

      if (w_cpu_en) begin
        if (~&r_retired) r_retired <= r_retired + CNT_W'(1);
        r_skip <= 1'b0;
        if (r_state == S_STEP) r_step_cnt <= r_step_cnt - CNT_W'(1);
      end

      case (r_state)
        S_HOLD: begin
          if (r_hold_cnt == '0) r_state <= S_HALT;
          else                  r_hold_cnt <= r_hold_cnt - HC_W'(1);
        end
        S_HALT: begin
          if (w_fire && io_cmd.cmd_op == OP_RUN) begin
            r_state  <= S_RUN;
            r_skip   <= 1'b1;
            r_bp_hit <= 1'b0;
          end else if (w_fire && io_cmd.cmd_op == OP_STEP) begin
            r_state    <= S_STEP;
            r_step_cnt <= w_step_load;
            r_skip     <= 1'b1;
            r_bp_hit   <= 1'b0;
          end
        end
        S_RUN, S_STEP: begin
          if (w_stop) begin
            r_state      <= S_HALT;
            r_bp_hit     <= 1'b1;
            r_bp_hit_idx <= ~w_m0;
          end else if (w_halt_cmd) begin
            r_state <= S_HALT;
          end else if (r_state == S_STEP && w_cpu_en && r_step_cnt == CNT_W'(1)) begin
            r_state <= S_HALT;
          end
        end
        default: r_state <= S_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_mips16_run_ctrl.sv
// tb/tb_mips16_run_ctrl.sv - scoreboard bench for mips16_run_ctrl with a behavioural model
module tb_mips16_run_ctrl;
  localparam int PC_W     = 16;
  localparam int CNT_W    = 16;
  localparam int HOLD_CYC = 4;

  localparam int M_HOLD = 0;
  localparam int M_HALT = 1;
  localparam int M_RUN  = 2;
  localparam int M_STEP = 3;

  typedef logic [21:0] obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n;
  logic [PC_W-1:0]  pc;
  logic             cpu_en, cpu_reset, halted, bp_hit, bp_hit_idx;
  logic [CNT_W-1:0] retired;

  mips16_run_ctrl_if #(.PC_W(PC_W)) cmd_if ();

  mips16_run_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W), .HOLD_CYC(HOLD_CYC)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .io_cmd       (cmd_if),
    .i_pc         (pc),
    .o_cpu_en     (cpu_en),
    .o_cpu_reset  (cpu_reset),
    .o_halted     (halted),
    .o_bp_hit     (bp_hit),
    .o_bp_hit_idx (bp_hit_idx),
    .o_retired    (retired)
  );

  // reference model: mode, remaining hold cycles, breakpoints, pending skip, steps left
  int          m_mode = M_HOLD;
  int          m_hold_left = HOLD_CYC;
  bit          m_bp_on [2];
  logic [15:0] m_bp_at [2];
  bit          m_skip = 0;
  int          m_steps_left = 0;
  int          m_retired = 0;
  bit          m_hit = 0;
  bit          m_hit_idx = 0;

  obs_t sb_q[$];
  obs_t mon_exp, mon_got;
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  bit   push_en = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic model_cycle(input bit rn, input bit v, input logic [2:0] op,
                             input bit idx, input logic [15:0] data);
    bit rdy, fire, hit0, hit1, brk, run_like, commit;
    rdy      = (m_mode != M_HOLD);
    fire     = v && rdy;
    hit0     = m_bp_on[0] && (pc == m_bp_at[0]);
    hit1     = m_bp_on[1] && (pc == m_bp_at[1]);
    brk      = (hit0 || hit1) && !m_skip;
    run_like = (m_mode == M_RUN) || (m_mode == M_STEP);
    commit   = run_like && !brk && !(fire && (op == 3'd0 || op == 3'd5));
    if (push_en)
      sb_q.push_back({commit, m_mode == M_HOLD, m_mode == M_HALT, rdy,
                      m_hit, m_hit_idx, 16'(m_retired)});
    if (!rn) begin
      m_mode = M_HOLD; m_hold_left = HOLD_CYC;
      m_bp_on[0] = 0; m_bp_on[1] = 0; m_bp_at[0] = 0; m_bp_at[1] = 0;
      m_skip = 0; m_steps_left = 0; m_retired = 0; m_hit = 0; m_hit_idx = 0;
      return;
    end
    if (fire && op == 3'd5) begin
      m_mode = M_HOLD; m_hold_left = HOLD_CYC;
      m_retired = 0; m_skip = 0; m_hit = 0;
      return;
    end
    if (fire && op == 3'd3) begin m_bp_on[idx] = 1; m_bp_at[idx] = data; end
    if (fire && op == 3'd4) m_bp_on[idx] = 0;
    if (commit) begin
      if (m_retired < 65535) m_retired++;
      m_skip = 0;
    end
    if (m_mode == M_HOLD) begin
      m_hold_left--;
      if (m_hold_left == 0) m_mode = M_HALT;
    end else if (m_mode == M_HALT) begin
      if (fire && op == 3'd1) begin
        m_mode = M_RUN; m_skip = 1; m_hit = 0;
      end else if (fire && op == 3'd2) begin
        m_mode = M_STEP; m_steps_left = (data == 0) ? 1 : int'(data);
        m_skip = 1; m_hit = 0;
      end
    end else begin
      if (brk) begin
        m_mode = M_HALT; m_hit = 1; m_hit_idx = hit0 ? 1'b0 : 1'b1;
      end else if (fire && op == 3'd0) begin
        m_mode = M_HALT;
      end else if (commit && m_mode == M_STEP) begin
        m_steps_left--;
        if (m_steps_left == 0) m_mode = M_HALT;
      end else if (commit) begin
        m_steps_left = m_steps_left;
      end
    end
  endtask

  // one cycle of stimulus; the core model advances pc on the DUT's own commits
  task automatic drive(input bit rn, input bit v, input logic [2:0] op,
                       input bit idx, input logic [15:0] data, input bit jump);
    bit en_s, rst_s;
    reset_n          = rn;
    cmd_if.cmd_valid = v;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_idx   = idx;
    cmd_if.cmd_data  = data;
    model_cycle(rn, v, op, idx, data);
    @(negedge clk);
    en_s  = (cpu_en === 1'b1);
    rst_s = (cpu_reset === 1'b1);
    @(posedge clk);
    #1;
    cyc++;
    if (rst_s)      pc = '0;
    else if (en_s)  pc = jump ? (16'($urandom_range(0, 16)) << 1) : pc + 16'd2;
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'b0, 3'd0, 1'b0, 16'd0, 1'b0);
  endtask

  task automatic cmd(input logic [2:0] op, input bit idx, input logic [15:0] data);
    drive(1'b1, 1'b1, op, idx, data, 1'b0);
  endtask

  // monitor: every observed cycle is compared against the queued model output
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_exp = sb_q.pop_front();
      mon_got = {cpu_en, cpu_reset, halted, cmd_if.cmd_ready, bp_hit, bp_hit_idx, retired};
      check("outputs{en,rst,halted,ready,hit,idx,retired}", 32'(mon_got), 32'(mon_exp));
    end
  end

  initial begin
    logic [2:0]  r_op;
    logic [15:0] r_data;
    pc = '0;
    reset_n = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op = 3'd0;
    cmd_if.cmd_idx = 1'b0;
    cmd_if.cmd_data = '0;
    @(posedge clk); #1;

    drive(1'b0, 1'b0, 3'd0, 1'b0, 16'd0, 1'b0);
    push_en = 1;
    drive(1'b0, 1'b0, 3'd0, 1'b0, 16'd0, 1'b0);
    idle(6);

    cmd(3'd2, 1'b0, 16'd3);
    idle(5);
    check("step3_pc", 32'(pc), 32'd6);

    cmd(3'd5, 1'b0, 16'd0);
    idle(6);
    cmd(3'd3, 1'b0, 16'h000A);
    cmd(3'd1, 1'b0, 16'd0);
    idle(10);
    check("bp0_stop_pc", 32'(pc), 32'h000A);
    cmd(3'd1, 1'b0, 16'd0);
    idle(3);
    check("bp_step_off", 32'(pc > 16'h000A), 32'd1);
    cmd(3'd0, 1'b0, 16'd0);
    idle(2);

    cmd(3'd5, 1'b0, 16'd0);
    idle(6);
    cmd(3'd3, 1'b0, 16'h0004);
    cmd(3'd3, 1'b1, 16'h0004);
    cmd(3'd1, 1'b0, 16'd0);
    idle(5);
    check("dual_bp_pc", 32'(pc), 32'h0004);
    cmd(3'd4, 1'b0, 16'd0);
    cmd(3'd1, 1'b0, 16'd0);
    idle(3);
    check("clr_bp_run_pc", 32'(pc), 32'h000A);
    cmd(3'd0, 1'b0, 16'd0);
    idle(1);
    check("halt_cmd_pc", 32'(pc), 32'h000A);
    cmd(3'd2, 1'b0, 16'd0);
    idle(3);
    check("step0_pc", 32'(pc), 32'h000C);

    cmd(3'd5, 1'b0, 16'd0);
    idle(6);
    cmd(3'd1, 1'b0, 16'd0);
    idle(2);
    cmd(3'd5, 1'b0, 16'd0);
    idle(6);
    cmd(3'd1, 1'b0, 16'd0);
    idle(4);
    check("bp1_kept_pc", 32'(pc), 32'h0004);

    cmd(3'd2, 1'b0, 16'd10);
    idle(2);
    drive(1'b0, 1'b0, 3'd0, 1'b0, 16'd0, 1'b0);
    idle(6);
    cmd(3'd1, 1'b0, 16'd0);
    idle(5);
    check("reset_clears_bp_pc", 32'(pc), 32'd10);

    repeat (800) begin
      r_op = 3'($urandom_range(0, 7));
      if (r_op == 3'd2) r_data = 16'($urandom_range(0, 6));
      else              r_data = 16'($urandom_range(0, 16)) << 1;
      drive(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) == 0), r_op,
            1'($urandom_range(0, 1)), r_data, ($urandom_range(0, 5) == 0));
    end

    push_en = 0;
    idle(2);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
